// File: rtl/pb_pkg.sv
// Shared definitions for the push-button scan controller: FSM encoding,
// default timing constants and a constant-evaluable ceil(log2) helper.
package pb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_UPDATE = 2'd2
  } scan_state_e;

  localparam int TICK_DIV_DFLT = 100000;
  localparam int HIST_W_DFLT   = 8;

  // Bits needed to hold values 0..v-1; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pb_scan_ctrl_if.sv
// Button-side bundle of the scan controller: raw inputs and scan enable in,
// debounced level, event pulses and current scan channel out.
interface pb_scan_ctrl_if import pb_pkg::*; #(
  parameter int N_BTN = 4
) ();

  localparam int IDX_W = clog2(N_BTN);

  logic             enable;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;
  logic [IDX_W-1:0] scan_idx;

  modport master (
    output enable, btn_raw,
    input  btn_level, btn_press, btn_release, btn_repeat, scan_idx
  );

  modport slave (
    input  enable, btn_raw,
    output btn_level, btn_press, btn_release, btn_repeat, scan_idx
  );

endinterface

// File: rtl/pb_tick_gen.sv
// Scan-slot divider: counts 0..TICK_DIV-1 while enabled and flags the last
// count as a one-cycle tick; disabling parks the counter at zero.
module pb_tick_gen import pb_pkg::*; #(
  parameter int TICK_DIV = TICK_DIV_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  output logic tick_o
);

  localparam int            CW   = clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!enable_i || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/pb_scan_ctrl.sv
// Round-robin debouncer: one shared SAMPLE/UPDATE datapath visits a single
// channel per scan tick and emits press, release and auto-repeat pulses.
module pb_scan_ctrl import pb_pkg::*; #(
  parameter int N_BTN      = 4,
  parameter int TICK_DIV   = TICK_DIV_DFLT,
  parameter int HIST_W     = HIST_W_DFLT,
  parameter int REPEAT_DLY = 500,
  parameter int REPEAT_PER = 100
) (
  input  logic           clk,
  input  logic           rst_n,
  pb_scan_ctrl_if.slave  bus
);

  localparam int IDX_W = clog2(N_BTN);
  localparam int RC_W  = (REPEAT_DLY > 0) ? clog2(REPEAT_DLY + 1) : 1;
  localparam int RELOAD_I = (REPEAT_DLY > REPEAT_PER) ? (REPEAT_DLY - REPEAT_PER) : 0;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BTN - 1);
  localparam logic [RC_W:0]    DLY_C    = (RC_W + 1)'(REPEAT_DLY);
  localparam logic [RC_W-1:0]  RELOAD   = RC_W'(RELOAD_I);

  logic tick;

  pb_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (bus.enable),
    .tick_o   (tick)
  );

  // Raw buttons are asynchronous; only the 2nd flop is ever sampled.
  logic [N_BTN-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    sync1_q <= bus.btn_raw;
    sync2_q <= sync1_q;
  end

  scan_state_e       state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [HIST_W-1:0] hist_q [N_BTN];
  logic [RC_W-1:0]   rcnt_q [N_BTN];
  logic [N_BTN-1:0]  level_q;
  logic [N_BTN-1:0]  press_q;
  logic [N_BTN-1:0]  release_q;
  logic [N_BTN-1:0]  rpt_q;

  logic [HIST_W-1:0] hist_cur;
  logic              hist_ones;
  logic              hist_zeros;
  logic              lvl_cur;
  logic [RC_W:0]     rcnt_inc;

  always_comb begin
    hist_cur   = hist_q[idx_q];
    hist_ones  = &hist_cur;
    hist_zeros = ~|hist_cur;
    lvl_cur    = level_q[idx_q];
    rcnt_inc   = {1'b0, rcnt_q[idx_q]} + (RC_W + 1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      rpt_q     <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        hist_q[i] <= '0;
        rcnt_q[i] <= '0;
      end
    end else begin
      // Pulses live for exactly the one cycle following UPDATE.
      press_q   <= '0;
      release_q <= '0;
      rpt_q     <= '0;
      case (state_q)
        ST_IDLE: begin
          if (tick) state_q <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          hist_q[idx_q] <= {hist_cur[HIST_W-2:0], sync2_q[idx_q]};
          state_q       <= ST_UPDATE;
        end
        ST_UPDATE: begin
          // Hysteresis: only a uniform window may flip the level.
          if (hist_ones && !lvl_cur) begin
            level_q[idx_q] <= 1'b1;
            press_q[idx_q] <= 1'b1;
            rcnt_q[idx_q]  <= '0;
          end else if (hist_zeros && lvl_cur) begin
            level_q[idx_q]   <= 1'b0;
            release_q[idx_q] <= 1'b1;
            rcnt_q[idx_q]    <= '0;
          end else if (hist_ones && lvl_cur && REPEAT_DLY != 0) begin
            if (rcnt_inc == DLY_C) begin
              rpt_q[idx_q]  <= 1'b1;
              rcnt_q[idx_q] <= RELOAD;
            end else begin
              rcnt_q[idx_q] <= rcnt_inc[RC_W-1:0];
            end
          end
          idx_q   <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.btn_repeat  = rpt_q;
  assign bus.scan_idx    = idx_q;

endmodule

// File: tb/tb_pb_scan_ctrl.sv
// Scoreboard bench for pb_scan_ctrl: directed button scenarios push expected
// pulses; a negedge monitor pops and compares whenever any pulse appears.
module tb_pb_scan_ctrl;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pb_scan_ctrl_if #(.N_BTN(N)) bus ();
  pb_scan_ctrl_if #(.N_BTN(N)) bus0 ();

  assign bus0.enable  = bus.enable;
  assign bus0.btn_raw = bus.btn_raw;

  pb_scan_ctrl #(
    .N_BTN(N), .TICK_DIV(4), .HIST_W(4), .REPEAT_DLY(3), .REPEAT_PER(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pb_scan_ctrl #(
    .N_BTN(N), .TICK_DIV(4), .HIST_W(4), .REPEAT_DLY(0), .REPEAT_PER(2)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  int tests = 0;
  int fails = 0;
  logic [11:0] exp_q [$];
  int d0_press = 0;
  int d0_rel   = 0;
  int d0_rpt   = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // kind 0 = press, 1 = release, 2 = repeat; packed as {press,release,repeat}
  function automatic logic [11:0] ev(input int kind, input int ch);
    logic [11:0] v;
    v = '0;
    v[(2 - kind) * 4 + ch] = 1'b1;
    return v;
  endfunction

  always @(negedge clk) begin
    logic [11:0] got;
    logic [11:0] e;
    got = {bus.btn_press, bus.btn_release, bus.btn_repeat};
    if (got != 12'h000) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pulse_unexpected: got %03h expected none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          fails++;
          $display("FAIL pulse_match: got %03h expected %03h", got, e);
        end
      end
    end
    d0_press += $countones(bus0.btn_press);
    d0_rel   += $countones(bus0.btn_release);
    d0_rpt   += $countones(bus0.btn_repeat);
  end

  task automatic wait_visit(input int ch);
    int prev;
    bit done;
    prev = int'(bus.scan_idx);
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (prev == ch && int'(bus.scan_idx) != ch) done = 1'b1;
      prev = int'(bus.scan_idx);
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL visit_timeout: ch%0d not visited within 200 clk", ch);
    end
  endtask

  task automatic run_visits(input int ch, input int n, input bit from_lvl,
                            input bit to_lvl, input string nm);
    int pend;
    pend = exp_q.size();
    for (int v = 1; v <= n; v++) begin
      wait_visit(ch);
      #1;
      check({nm, "_level"}, int'(bus.btn_level[ch]),
            (v == n) ? int'(to_lvl) : int'(from_lvl));
      check({nm, "_pending"}, exp_q.size(), (v == n) ? 0 : pend);
    end
  endtask

  initial begin
    int cyc, last, prev, changes, lvl_bad, idx_bad;

    rst_n       = 1'b1;
    bus.enable  = 1'b1;
    bus.btn_raw = '0;
    #1 rst_n = 1'b0;

    // Reset state and free-running scan order
    repeat (5) @(negedge clk);
    check("rst_level", bus.btn_level, 0);
    check("rst_idx", bus.scan_idx, 0);
    check("rst_pulses", {bus.btn_press, bus.btn_release, bus.btn_repeat}, 0);
    rst_n = 1'b1;
    cyc = 0; last = 0; prev = 0; changes = 0; lvl_bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.btn_level != '0) lvl_bad++;
      if (int'(bus.scan_idx) != prev) begin
        changes++;
        if (changes <= 5) begin
          check("scan_seq", bus.scan_idx, (prev + 1) % 4);
          check("scan_gap", cyc - last, (changes == 1) ? 6 : 4);
        end
        last = cyc;
        prev = int'(bus.scan_idx);
      end
    end
    check("idle_level", lvl_bad, 0);
    check("scan_changes", changes, 49);

    // Clean press and release on ch0
    wait_visit(0);
    bus.btn_raw[0] = 1'b1;
    exp_q.push_back(ev(0, 0));
    run_visits(0, 4, 1'b0, 1'b1, "ch0_press");
    bus.btn_raw[0] = 1'b0;
    exp_q.push_back(ev(1, 0));
    run_visits(0, 4, 1'b1, 1'b0, "ch0_release");

    // Bouncing ch1: toggles every 3 ticks never give 4 equal samples
    for (int t = 0; t < 34; t++) begin
      bus.btn_raw[1] = ~bus.btn_raw[1];
      repeat (12) @(negedge clk);
    end
    bus.btn_raw[1] = 1'b0;
    run_visits(1, 5, 1'b0, 1'b0, "ch1_bounce");
    bus.btn_raw[1] = 1'b1;
    exp_q.push_back(ev(0, 1));
    run_visits(1, 4, 1'b0, 1'b1, "ch1_press");
    bus.btn_raw[1] = 1'b0;
    exp_q.push_back(ev(1, 1));
    run_visits(1, 4, 1'b1, 1'b0, "ch1_release");

    // Hysteresis on ch2: a one-visit glitch leaves the level alone
    wait_visit(2);
    bus.btn_raw[2] = 1'b1;
    exp_q.push_back(ev(0, 2));
    run_visits(2, 4, 1'b0, 1'b1, "ch2_press");
    bus.btn_raw[2] = 1'b0;
    run_visits(2, 1, 1'b1, 1'b1, "ch2_glitch");
    bus.btn_raw[2] = 1'b1;
    run_visits(2, 2, 1'b1, 1'b1, "ch2_recover");
    bus.btn_raw[2] = 1'b0;
    exp_q.push_back(ev(1, 2));
    run_visits(2, 4, 1'b1, 1'b0, "ch2_release");

    // Auto-repeat on ch3: 3rd visit after press, then every 2nd
    wait_visit(3);
    bus.btn_raw[3] = 1'b1;
    exp_q.push_back(ev(0, 3));
    run_visits(3, 4, 1'b0, 1'b1, "ch3_press");
    exp_q.push_back(ev(2, 3));
    run_visits(3, 3, 1'b1, 1'b1, "ch3_rpt1");
    exp_q.push_back(ev(2, 3));
    run_visits(3, 2, 1'b1, 1'b1, "ch3_rpt2");
    exp_q.push_back(ev(2, 3));
    run_visits(3, 2, 1'b1, 1'b1, "ch3_rpt3");
    bus.btn_raw[3] = 1'b0;
    exp_q.push_back(ev(1, 3));
    run_visits(3, 4, 1'b1, 1'b0, "ch3_release");

    // Freeze with ch0 held: nothing moves while enable is low
    wait_visit(0);
    bus.btn_raw[0] = 1'b1;
    exp_q.push_back(ev(0, 0));
    run_visits(0, 4, 1'b0, 1'b1, "ch0_press2");
    bus.enable = 1'b0;
    idx_bad = 0; lvl_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bus.btn_raw = 4'($urandom);
      if (bus.scan_idx != 2'd1) idx_bad++;
      if (bus.btn_level != 4'b0001) lvl_bad++;
    end
    bus.btn_raw = 4'b0001;
    repeat (3) @(negedge clk);
    check("freeze_idx", idx_bad, 0);
    check("freeze_level", lvl_bad, 0);
    bus.enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("resume_idx", bus.scan_idx, (k == 6) ? 2 : 1);
    end
    exp_q.push_back(ev(2, 0));
    run_visits(0, 3, 1'b1, 1'b1, "ch0_rpt_after_freeze");

    check("norpt_press_cnt", d0_press, 5);
    check("norpt_release_cnt", d0_rel, 4);
    check("norpt_repeat_cnt", d0_rpt, 0);
    check("norpt_level", bus0.btn_level, 1);

    // Asynchronous reset landing in ch1's UPDATE cycle
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_level", bus.btn_level, 0);
    check("midrst_idx", bus.scan_idx, 0);
    check("midrst_pulses", {bus.btn_press, bus.btn_release, bus.btn_repeat}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pb_scan_ctrl.md
Name: pb_scan_ctrl

Overview:
Scheduler that shares one debounce datapath across N_BTN push-buttons. It generates its own scan tick from clk and visits one channel per tick in round-robin order. On each visit it shifts that channel's synchronized sample into its history register, evaluates the result, and updates the stable level. Outputs are one-clk press, release and auto-repeat pulses for the scoreboard control logic.

Parameters:
N_BTN, 4, number of button channels (2..16)
TICK_DIV, 100000, clk cycles per scan slot (100 MHz -> 1 ms); must be >= 4
HIST_W, 8, history bits per channel (debounce window = HIST_W visits)
REPEAT_DLY, 500, all-ones visits after press before first repeat; 0 disables repeat
REPEAT_PER, 100, visits between subsequent repeats; must be 1..REPEAT_DLY

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scan enable; low freezes scanning
btn_raw  in  N_BTN  asynchronous raw button inputs
btn_level  out  N_BTN  debounced stable level per channel
btn_press  out  N_BTN  one-clk pulse on 0->1 of btn_level
btn_release  out  N_BTN  one-clk pulse on 1->0 of btn_level
btn_repeat  out  N_BTN  one-clk auto-repeat pulse while held
scan_idx  out  clog2(N_BTN)  channel currently being scanned

Behaviour:
- Reset (async, rst_n=0): tick counter 0, state IDLE, scan_idx 0, all hist 0, btn_level 0, all pulse outputs 0, repeat counters 0.
- btn_raw passes through a 2-flop synchronizer (sync). Its contents after reset are don't-care, but the first visits must not produce a press.
- Tick: counter counts 0..TICK_DIV-1, then wraps; tick=1 when counter==TICK_DIV-1. enable=0 holds the counter at 0 and suppresses ticks.
- FSM states: IDLE, SAMPLE, UPDATE.
  - IDLE --tick--> SAMPLE.
  - SAMPLE: hist[idx] <= {hist[idx][HIST_W-2:0], sync[idx]}; -> UPDATE.
  - UPDATE: evaluate the new hist[idx]; scan_idx <= (idx==N_BTN-1) ? 0 : idx+1; -> IDLE.
  - An in-flight SAMPLE/UPDATE always completes even if enable drops.
- Evaluation in UPDATE, with hysteresis:
  - all ones and level=0 -> level<=1, press pulse, rcnt<=0.
  - all zeros and level=1 -> level<=0, release pulse, rcnt<=0.
  - mixed -> level unchanged.
  - level=1, all ones, no press this visit, REPEAT_DLY!=0: rcnt++. When rcnt+1==REPEAT_DLY, repeat pulse and rcnt<=REPEAT_DLY-REPEAT_PER.
  - mixed history while level=1 -> rcnt holds.
- Pulses are registered in UPDATE and are high exactly the one clk after UPDATE. Latency from tick to pulse is 3 clk (tick, SAMPLE, UPDATE, pulse).
- Only one channel is updated per UPDATE, so at most one bit across press/release/repeat is high in any cycle. Press and repeat are never coincident.
- Minimum debounce time: HIST_W*N_BTN ticks of stable input.
- Width rule: rcnt per channel is clog2(REPEAT_DLY+1) bits and never exceeds REPEAT_DLY-1.

Decomposition:
- Package pb_pkg: FSM state encodings (IDLE/SAMPLE/UPDATE), default TICK_DIV and HIST_W constants, clog2 function.
- One sub-module, pb_tick_gen: the TICK_DIV divider with enable, producing the single-cycle tick.
- Channel history, level and rcnt stay as arrays inside pb_scan_ctrl.

Test Plan (TICK_DIV=4, N_BTN=4, HIST_W=4, REPEAT_DLY=3, REPEAT_PER=2 unless stated):
1. Reset: rst_n low then high with btn_raw=0 for 200 clk -> all outputs 0. scan_idx sequence 0,1,2,3,0 advances once per 4 clk. rst_n pulsed low mid-UPDATE -> outputs clear immediately.
2. Clean press: btn_raw[0]=1 held -> btn_level[0] rises on the 4th visit to ch0. btn_press=4'b0001 for exactly 1 clk. No other pulse bits are high.
3. Bounce: btn_raw[1] toggled every 3 ticks for 100 ticks -> btn_level[1] stays 0 with no pulses. Then held 1 -> single press after 4 ch1 visits.
4. Hysteresis/release: ch2 level=1, one-visit 0 glitch -> level stays 1 with no release. Held 0 for 4 visits -> btn_release=4'b0100 for 1 clk.
5. Auto-repeat: hold btn_raw[3] -> press, then btn_repeat[3] on the 3rd following visit and every 2nd visit after. With REPEAT_DLY=0, no repeats.
6. Freeze: enable=0 for 50 clk while btn_raw changes -> scan_idx, btn_level and hist unchanged, no pulses. Scanning resumes on the 4th clk after enable=1.
